// File: rtl/adder_eval_pkg.sv
// Shared types and width helpers for the approximate-adder error monitor.
package adder_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Stages from accept to accumulator update: S1, S2, S3.
  localparam int PIPE_LAT = 3;

  function automatic int err_w(input int width);
    return width + 1;
  endfunction

  function automatic int sum_err_w(input int width, input int cnt_w);
    return width + 1 + cnt_w;
  endfunction

  function automatic int sq_err_w(input int width, input int cnt_w);
    return 2 * (width + 1) + cnt_w;
  endfunction

endpackage

// File: rtl/adder_err_calc.sv
// S1-S2 pipeline: registers the golden sum, then the absolute error and mismatch flag.
import adder_eval_pkg::*;

module adder_err_calc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   sum_approx,
  output logic             out_valid,
  output logic [WIDTH:0]   e,
  output logic             mismatch
);

  localparam int EW = err_w(WIDTH);

  logic          s1_valid_q, s1_valid_d;
  logic [EW-1:0] golden_q, golden_d;
  logic [EW-1:0] approx_q, approx_d;
  logic          s2_valid_q, s2_valid_d;
  logic [EW-1:0] e_q, e_d;
  logic          mismatch_q, mismatch_d;

  always_comb begin
    s1_valid_d = in_valid;
    golden_d   = {1'b0, a} + {1'b0, b};
    approx_d   = sum_approx;
    s2_valid_d = s1_valid_q;
    e_d        = '0;
    mismatch_d = 1'b0;
    // Bubbles leave e and the flag at zero so they can never contribute.
    if (s1_valid_q) begin
      e_d        = (golden_q >= approx_q) ? (golden_q - approx_q) : (approx_q - golden_q);
      mismatch_d = (e_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      golden_q   <= '0;
      approx_q   <= '0;
      s2_valid_q <= 1'b0;
      e_q        <= '0;
      mismatch_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      golden_q   <= golden_d;
      approx_q   <= approx_d;
      s2_valid_q <= s2_valid_d;
      e_q        <= e_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign e         = e_q;
  assign mismatch  = mismatch_q;

endmodule

// File: rtl/adder_error_monitor.sv
// Windowed error statistics for an approximate adder: FSM plus S3 accumulators.
// Optional ADDER_ERR_SQ_EN adds a sum-of-squared-error output.
import adder_eval_pkg::*;

module adder_error_monitor #(
  parameter int WIDTH     = 8,
  parameter int N_SAMPLES = 256,
  parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic [WIDTH:0]               sum_approx,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             err_count,
  output logic [WIDTH+CNT_W:0]         sum_abs_err,
`ifdef ADDER_ERR_SQ_EN
  output logic [2*(WIDTH+1)+CNT_W-1:0] sum_sq_err,
`endif
  output logic [WIDTH:0]               max_abs_err
);

  localparam int ERR_W     = err_w(WIDTH);
  localparam int SUM_ERR_W = sum_err_w(WIDTH, CNT_W);
  localparam logic [CNT_W-1:0] N_LIMIT  = CNT_W'(N_SAMPLES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);
  // DRAIN covers the two stages still in flight after the last accept.
  localparam logic [1:0] DRAIN_LAST = 2'(PIPE_LAT - 2);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       accepted_q, accepted_d;
  logic [1:0]             drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]       err_count_q, err_count_d;
  logic [SUM_ERR_W-1:0]   sum_abs_err_q, sum_abs_err_d;
  logic [ERR_W-1:0]       max_abs_err_q, max_abs_err_d;
  logic                   clear_results;
  logic                   accept;
  logic                   calc_valid;
  logic [ERR_W-1:0]       calc_e;
  logic                   calc_mismatch;

`ifdef ADDER_ERR_SQ_EN
  localparam int SQ_ERR_W = sq_err_w(WIDTH, CNT_W);
  logic [SQ_ERR_W-1:0]    sum_sq_err_q, sum_sq_err_d;
  logic [2*ERR_W-1:0]     e_sq;
`endif

  assign in_ready = (state_q == RUN) && (accepted_q < N_LIMIT);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);

  adder_err_calc #(.WIDTH(WIDTH)) u_calc (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (accept),
    .a          (a),
    .b          (b),
    .sum_approx (sum_approx),
    .out_valid  (calc_valid),
    .e          (calc_e),
    .mismatch   (calc_mismatch)
  );

  always_comb begin
    state_d       = state_q;
    accepted_d    = accepted_q;
    drain_cnt_d   = drain_cnt_q;
    clear_results = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d       = RUN;
          accepted_d    = '0;
          clear_results = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          accepted_d = accepted_q + 1'b1;
          if (accepted_q == LAST_IDX) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_count_d   = err_count_q;
    sum_abs_err_d = sum_abs_err_q;
    max_abs_err_d = max_abs_err_q;
`ifdef ADDER_ERR_SQ_EN
    e_sq         = {{ERR_W{1'b0}}, calc_e} * {{ERR_W{1'b0}}, calc_e};
    sum_sq_err_d = sum_sq_err_q;
`endif
    if (clear_results) begin
      err_count_d   = '0;
      sum_abs_err_d = '0;
      max_abs_err_d = '0;
`ifdef ADDER_ERR_SQ_EN
      sum_sq_err_d  = '0;
`endif
    end else if (calc_valid) begin
      err_count_d   = err_count_q + CNT_W'(calc_mismatch);
      sum_abs_err_d = sum_abs_err_q + SUM_ERR_W'(calc_e);
      max_abs_err_d = (calc_e > max_abs_err_q) ? calc_e : max_abs_err_q;
`ifdef ADDER_ERR_SQ_EN
      sum_sq_err_d  = sum_sq_err_q + SQ_ERR_W'(e_sq);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      accepted_q    <= '0;
      drain_cnt_q   <= '0;
      err_count_q   <= '0;
      sum_abs_err_q <= '0;
      max_abs_err_q <= '0;
`ifdef ADDER_ERR_SQ_EN
      sum_sq_err_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      accepted_q    <= accepted_d;
      drain_cnt_q   <= drain_cnt_d;
      err_count_q   <= err_count_d;
      sum_abs_err_q <= sum_abs_err_d;
      max_abs_err_q <= max_abs_err_d;
`ifdef ADDER_ERR_SQ_EN
      sum_sq_err_q  <= sum_sq_err_d;
`endif
    end
  end

  assign err_count   = err_count_q;
  assign sum_abs_err = sum_abs_err_q;
  assign max_abs_err = max_abs_err_q;
`ifdef ADDER_ERR_SQ_EN
  assign sum_sq_err  = sum_sq_err_q;
`endif

endmodule

// File: tb/tb_adder_error_monitor.sv
// Directed, table-driven bench for adder_error_monitor (4-sample and 256-sample instances).
module tb_adder_error_monitor;

  typedef struct {
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [3:0][8:0] s;
    int              gaps;
    bit              start_mid;
    int              exp_cnt;
    int              exp_sum;
    int              exp_max;
    int              exp_sq;
  } window_t;

  logic clk;
  logic rst;

  logic        start, in_valid, in_ready, busy, done;
  logic [7:0]  a, b;
  logic [8:0]  sum_approx;
  logic [2:0]  err_count;
  logic [11:0] sum_abs_err;
  logic [8:0]  max_abs_err;
`ifdef ADDER_ERR_SQ_EN
  logic [20:0] sum_sq_err;
`endif

  logic        w_start, w_in_valid, w_in_ready, w_busy, w_done;
  logic [7:0]  w_a, w_b;
  logic [8:0]  w_sum_approx;
  logic [8:0]  w_err_count;
  logic [17:0] w_sum_abs_err;
  logic [8:0]  w_max_abs_err;
`ifdef ADDER_ERR_SQ_EN
  logic [26:0] w_sum_sq_err;
`endif

  int checks = 0;
  int errors = 0;
  window_t tbl [3];

  adder_error_monitor #(.WIDTH(8), .N_SAMPLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .sum_approx  (sum_approx),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .sum_abs_err (sum_abs_err),
`ifdef ADDER_ERR_SQ_EN
    .sum_sq_err  (sum_sq_err),
`endif
    .max_abs_err (max_abs_err)
  );

  adder_error_monitor #(.WIDTH(8), .N_SAMPLES(256)) dut_wide (
    .clk         (clk),
    .rst         (rst),
    .start       (w_start),
    .in_valid    (w_in_valid),
    .in_ready    (w_in_ready),
    .a           (w_a),
    .b           (w_b),
    .sum_approx  (w_sum_approx),
    .busy        (w_busy),
    .done        (w_done),
    .err_count   (w_err_count),
    .sum_abs_err (w_sum_abs_err),
`ifdef ADDER_ERR_SQ_EN
    .sum_sq_err  (w_sum_sq_err),
`endif
    .max_abs_err (w_max_abs_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkResults(input string tag, input int cnt, input int sum, input int mx, input int sq);
    checkOutput({tag, " err_count"}, 32'(err_count), 32'(cnt));
    checkOutput({tag, " sum_abs_err"}, 32'(sum_abs_err), 32'(sum));
    checkOutput({tag, " max_abs_err"}, 32'(max_abs_err), 32'(mx));
`ifdef ADDER_ERR_SQ_EN
    checkOutput({tag, " sum_sq_err"}, 32'(sum_sq_err), 32'(sq));
`else
    if (sq < 0) $display("[TB] unexpected negative square expectation");
`endif
  endtask

  // Runs one 4-sample window from IDLE or DONE and checks handshake, latency and results.
  task automatic applyStimulus(input window_t w, input string tag);
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, " busy after start"}, 32'(busy), 32'd1);
    checkResults({tag, " cleared"}, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        for (int g = 0; g < w.gaps; g++) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      a          = w.a[i];
      b          = w.b[i];
      sum_approx = w.s[i];
      in_valid   = 1'b1;
      start      = (i == 2) ? w.start_mid : 1'b0;
      checkOutput({tag, " in_ready in RUN"}, 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    start      = 1'b0;
    a          = 8'd255;
    b          = 8'd255;
    sum_approx = 9'd0;
    in_valid   = 1'b1;
    checkOutput({tag, " in_ready after last accept"}, 32'(in_ready), 32'd0);
    checkOutput({tag, " busy in DRAIN"}, 32'(busy), 32'd1);
    checkOutput({tag, " done early"}, 32'(done), 32'd0);
    @(negedge clk);
    checkOutput({tag, " done one cycle early"}, 32'(done), 32'd0);
    @(negedge clk);
    checkOutput({tag, " done at latency"}, 32'(done), 32'd1);
    checkOutput({tag, " busy in DONE"}, 32'(busy), 32'd0);
    checkResults(tag, w.exp_cnt, w.exp_sum, w.exp_max, w.exp_sq);
    repeat (3) @(negedge clk);
    checkOutput({tag, " done held"}, 32'(done), 32'd1);
    checkResults({tag, " held"}, w.exp_cnt, w.exp_sum, w.exp_max, w.exp_sq);
    in_valid = 1'b0;
  endtask

  initial begin
    tbl[0].a = {8'd128, 8'd0, 8'd255, 8'd3};
    tbl[0].b = {8'd128, 8'd0, 8'd1,   8'd5};
    tbl[0].s = {9'd256, 9'd0, 9'd256, 9'd8};
    tbl[0].gaps = 0; tbl[0].start_mid = 1'b0;
    tbl[0].exp_cnt = 0; tbl[0].exp_sum = 0; tbl[0].exp_max = 0; tbl[0].exp_sq = 0;

    tbl[1].a = {8'd1, 8'd255, 8'd200, 8'd10};
    tbl[1].b = {8'd1, 8'd255, 8'd100, 8'd20};
    tbl[1].s = {9'd3, 9'd500, 9'd300, 9'd28};
    tbl[1].gaps = 0; tbl[1].start_mid = 1'b1;
    tbl[1].exp_cnt = 3; tbl[1].exp_sum = 13; tbl[1].exp_max = 10; tbl[1].exp_sq = 105;

    tbl[2].a = {8'd7,  8'd0, 8'd100, 8'd0};
    tbl[2].b = {8'd8,  8'd1, 8'd27,  8'd0};
    tbl[2].s = {9'd31, 9'd0, 9'd127, 9'd511};
    tbl[2].gaps = 2; tbl[2].start_mid = 1'b0;
    tbl[2].exp_cnt = 3; tbl[2].exp_sum = 528; tbl[2].exp_max = 511; tbl[2].exp_sq = 261378;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = '0; b = '0; sum_approx = '0;
    w_start = 1'b0; w_in_valid = 1'b0; w_a = '0; w_b = '0; w_sum_approx = '0;
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkResults("reset", 0, 0, 0, 0);
    in_valid = 1'b0;

    for (int k = 0; k < 3; k++) begin
      applyStimulus(tbl[k], $sformatf("win%0d", k));
    end

    // Reset after two accepts discards the partial window.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = 8'd255; b = 8'd255; sum_approx = 9'd0; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("partial err_count", 32'(err_count), 32'd2);
    checkOutput("partial max_abs_err", 32'(max_abs_err), 32'd510);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset done", 32'(done), 32'd0);
    checkOutput("midreset in_ready", 32'(in_ready), 32'd0);
    checkResults("midreset", 0, 0, 0, 0);
    rst = 1'b0;
    applyStimulus(tbl[1], "after_reset");

    // Full 256-sample worst-case window on the wide instance.
    @(negedge clk);
    w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      w_a = 8'd255; w_b = 8'd255; w_sum_approx = 9'd0; w_in_valid = 1'b1;
      if (i == 0 || i == 255) checkOutput("wide in_ready", 32'(w_in_ready), 32'd1);
      @(negedge clk);
    end
    checkOutput("wide in_ready after last", 32'(w_in_ready), 32'd0);
    begin
      int waited = 0;
      while (!w_done && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("wide done within bound", 32'(w_done), 32'd1);
    end
    w_in_valid = 1'b0;
    checkOutput("wide err_count", 32'(w_err_count), 32'd256);
    checkOutput("wide sum_abs_err", 32'(w_sum_abs_err), 32'd130560);
    checkOutput("wide max_abs_err", 32'(w_max_abs_err), 32'd510);
`ifdef ADDER_ERR_SQ_EN
    checkOutput("wide sum_sq_err", 32'(w_sum_sq_err), 32'd66585600);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
